// File: rtl/axif_frame_writer_if.sv
// AXI4 write-address/data/response channels plus the pixel stream that feeds them.
// master = the frame writer side, slave = the memory/stream side.
interface axif_frame_writer_if #(
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_WIDTH-1:0]   s_data;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    input  s_valid, s_data,
    output s_ready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    output s_valid, s_data,
    input  s_ready
  );
endinterface

// File: rtl/axif_frame_writer.sv
// AXI4 write master: streams one frame of pixel words into memory as INCR bursts,
// one burst outstanding at a time, never crossing a 4 KB boundary.
module axif_frame_writer #(
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-2:0] i_n_pixels,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  axif_frame_writer_if.master   axi
);

  localparam int unsigned CntW  = ADDR_WIDTH - 1;
  localparam int unsigned StrbW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CntW-1:0]       rem_q, rem_d;
  logic [8:0]            beat_q, beat_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [CntW-1:0]       room_c;
  logic [CntW-1:0]       beats_c;
  logic                  w_hs;
  logic                  b_bad;

  // Burst size: limited by remaining pixels, BURST_LEN and words left in this 4 KB page.
  always_comb begin
    room_c  = CntW'(11'd1024 - {1'b0, addr_q[11:2]});
    beats_c = CntW'(BURST_LEN);
    if (rem_q < beats_c) beats_c = rem_q;
    if (room_c < beats_c) beats_c = room_c;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    w_hs    = (state_q == StW) && axi.s_valid && axi.wready;
    b_bad   = (axi.bresp != 2'b00) || (axi.bid != ID_WIDTH'(AXI_ID));

    unique case (state_q)
      StIdle: begin
        // busy stays high through the done cycle so a coincident start is ignored
        if (done_q) begin
          busy_d = 1'b0;
        end else if (i_start && !busy_q) begin
          addr_d = i_base_addr & ~ADDR_WIDTH'(3);
          rem_d  = i_n_pixels;
          busy_d = 1'b1;
          err_d  = 1'b0;
          if (i_n_pixels == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StAw;
          end
        end
      end
      StAw: begin
        if (axi.awready) begin
          beat_d  = 9'(beats_c);
          state_d = StW;
        end
      end
      StW: begin
        if (w_hs) begin
          beat_d = beat_q - 9'd1;
          rem_d  = rem_q - CntW'(1);
          addr_d = addr_q + ADDR_WIDTH'(4);
          if (beat_q == 9'd1) state_d = StB;
        end
      end
      StB: begin
        if (axi.bvalid) begin
          if (b_bad) err_d = 1'b1;
          if (rem_q != '0) begin
            state_d = StAw;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign axi.awid    = ID_WIDTH'(AXI_ID);
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'(beats_c - CntW'(1));
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 1'b0;
  assign axi.awcache = 4'b0011;
  assign axi.awprot  = 3'b000;
  assign axi.awqos   = 4'b0000;
  assign axi.awvalid = (state_q == StAw);

  // W channel is a straight pass-through of the pixel stream while in StW.
  assign axi.wdata   = axi.s_data;
  assign axi.wstrb   = {StrbW{1'b1}};
  assign axi.wlast   = (state_q == StW) && (beat_q == 9'd1);
  assign axi.wvalid  = (state_q == StW) && axi.s_valid;
  assign axi.s_ready = (state_q == StW) && axi.wready;

  assign axi.bready  = (state_q == StB);

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_err  = err_q;

endmodule

// File: tb/tb_axif_frame_writer.sv
// Bench for axif_frame_writer: random slave/stream timing, expected bursts and data
// derived from burst-splitting arithmetic on the command.
module tb_axif_frame_writer;
  localparam int unsigned IdW = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 18;
  localparam int unsigned NW  = AW - 1;
  localparam int          BL  = 16;

  logic          clk = 1'b1;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [NW-1:0] i_n_pixels = '0;
  logic          o_busy, o_done, o_err;

  always #5 clk = ~clk;

  axif_frame_writer_if #(.ID_WIDTH(IdW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axif_frame_writer #(
    .ID_WIDTH(IdW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_n_pixels(i_n_pixels), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .axi(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_w = 0, n_wlast = 0, n_b = 0, n_done = 0;
  int viol_stab = 0, viol_fix = 0, viol_sr = 0, viol_seq = 0;
  int start_cyc = 0, done_cyc = 0, b_cyc = 0;
  logic [AW-1:0] aw_addr_q[$];
  logic [7:0]    aw_len_q[$];
  logic [31:0]   w_data_q[$];
  logic          w_last_q[$];
  logic          aw_hold = 1'b0, w_hold = 1'b0, h_last = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [7:0]    h_len = '0;
  logic [31:0]   h_data = '0;

  int aw_stall = 0, w_stall = 0, b_stall = 0, s_gap = 0;
  int err_b = -1;
  int src_base = 0, src_total = 0;
  int b_seen = 0, last_nw = 0;
  logic [31:0] gen [1024];

  // Slave and stream source: drive on the falling edge.
  always @(negedge clk) begin
    int idx;
    idx = n_w - src_base;
    bus.awready = ($urandom_range(0, 99) >= aw_stall);
    bus.wready  = ($urandom_range(0, 99) >= w_stall);
    bus.bid     = '0;
    if (rst) begin
      bus.bvalid  = 1'b0;
      bus.bresp   = 2'b00;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
    end else begin
      if (bus.bvalid && n_b != b_seen) bus.bvalid = 1'b0;
      if (!bus.bvalid && n_wlast > n_b && $urandom_range(0, 99) >= b_stall) begin
        bus.bvalid = 1'b1;
        bus.bresp  = (n_b == err_b) ? 2'b10 : 2'b00;
      end
      if (idx >= src_total) begin
        bus.s_valid = 1'b0;
      end else if (!(bus.s_valid && n_w == last_nw)) begin
        bus.s_valid = ($urandom_range(0, 99) >= s_gap);
        bus.s_data  = gen[(src_base + idx) % 1024];
      end
    end
    b_seen  = n_b;
    last_nw = n_w;
  end

  // Monitor: record handshakes and protocol violations on the rising edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      aw_hold = 1'b0;
      w_hold  = 1'b0;
    end else begin
      if (i_start && !o_busy) start_cyc = cyc;
      if (o_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (aw_hold && (!bus.awvalid || bus.awaddr != h_addr || bus.awlen != h_len)) viol_stab++;
      if (w_hold && (!bus.wvalid || bus.wdata != h_data || bus.wlast != h_last)) viol_stab++;
      if (bus.awvalid && (bus.awid != '0 || bus.awsize != 3'b010 || bus.awburst != 2'b01 ||
          bus.awlock || bus.awcache != 4'b0011 || bus.awprot != 3'b0 || bus.awqos != 4'b0))
        viol_fix++;
      if (bus.wvalid && bus.wstrb != 4'hF) viol_fix++;
      if (bus.wvalid && bus.s_ready !== bus.wready) viol_sr++;
      if ((bus.awvalid || bus.bready) && bus.s_ready) viol_sr++;
      if (bus.awvalid && (bus.wvalid || bus.bready)) viol_seq++;
      if (bus.wvalid && bus.bready) viol_seq++;
      aw_hold = bus.awvalid && !bus.awready;
      h_addr  = bus.awaddr;
      h_len   = bus.awlen;
      w_hold  = bus.wvalid && !bus.wready;
      h_data  = bus.wdata;
      h_last  = bus.wlast;
      if (bus.awvalid && bus.awready) begin
        aw_addr_q.push_back(bus.awaddr);
        aw_len_q.push_back(bus.awlen);
      end
      if (bus.wvalid && bus.wready) begin
        w_data_q.push_back(bus.wdata);
        w_last_q.push_back(bus.wlast);
        n_w++;
        if (bus.wlast) n_wlast++;
      end
      if (bus.bvalid && bus.bready) begin
        n_b++;
        b_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [AW-1:0] base, input int n, input int err_rel,
                         input bit inject);
    int aw0, w0, d0, b0, rem, beats, room;
    bit inj_done;
    logic [AW-1:0] a;
    logic [AW-1:0] exp_a[$];
    logic [7:0]    exp_l[$];
    logic          exp_last[$];
    aw0 = aw_addr_q.size();
    w0  = w_data_q.size();
    d0  = n_done;
    b0  = n_b;
    src_base = n_w;
    for (int i = 0; i < n; i++) gen[(n_w + i) % 1024] = $urandom;
    src_total = n;
    err_b = (err_rel < 0) ? -1 : b0 + err_rel;
    i_start = 1'b1;
    i_base_addr = base;
    i_n_pixels = NW'(n);
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1);
    inj_done = 1'b0;
    for (int c = 0; c < 5000 && n_done == d0; c++) begin
      if (inject && !inj_done && n_b >= b0 + 2) begin
        i_start = 1'b1;
        i_base_addr = 'h100;
        i_n_pixels = 3;
        inj_done = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_count", n_done - d0, 1);
    chk("busy_end", o_busy, 0);
    chk("err_end", o_err, err_rel >= 0);

    // Reference split: min(remaining, BURST_LEN, words to next 4 KB page).
    a = base & ~AW'(3);
    rem = n;
    while (rem > 0) begin
      room = (4096 - (int'(a) % 4096)) / 4;
      beats = rem;
      if (BL < beats) beats = BL;
      if (room < beats) beats = room;
      exp_a.push_back(a);
      exp_l.push_back(8'(beats - 1));
      for (int j = 0; j < beats; j++) exp_last.push_back(j == beats - 1);
      a = a + AW'(4 * beats);
      rem -= beats;
    end
    chk("aw_count", aw_addr_q.size() - aw0, exp_a.size());
    if (aw_addr_q.size() - aw0 == exp_a.size()) begin
      foreach (exp_a[i]) begin
        chk($sformatf("awaddr[%0d]", i), aw_addr_q[aw0 + i], exp_a[i]);
        chk($sformatf("awlen[%0d]", i), aw_len_q[aw0 + i], exp_l[i]);
      end
    end
    chk("beat_count", w_data_q.size() - w0, n);
    if (w_data_q.size() - w0 == n) begin
      for (int k = 0; k < n; k++) begin
        chk($sformatf("wdata[%0d]", k), w_data_q[w0 + k], gen[(src_base + k) % 1024]);
        chk($sformatf("wlast[%0d]", k), w_last_q[w0 + k], exp_last[k]);
      end
    end
    chk("stable", viol_stab, 0);
    chk("fixed_fields", viol_fix, 0);
    chk("s_ready", viol_sr, 0);
    chk("sequential", viol_seq, 0);
  endtask

  initial begin
    logic [AW-1:0] rb;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_wlast", bus.wlast, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    rst = 1'b0;
    @(negedge clk);

    run_cmd('h0000, 16, -1, 0);
    chk("done_after_b", done_cyc - b_cyc, 1);
    run_cmd('h0000, 37, -1, 0);
    run_cmd('h0FF0, 8, -1, 0);

    aw_stall = 30; w_stall = 30; b_stall = 30; s_gap = 30;
    rb = AW'($urandom);
    run_cmd(rb, 100, -1, 0);

    aw_stall = 20; w_stall = 20; b_stall = 20; s_gap = 20;
    run_cmd('h0000, 40, 1, 1);
    repeat (5) @(negedge clk);
    chk("err_sticky", o_err, 1);
    run_cmd('h0040, 0, -1, 0);
    chk("done_after_start_n0", done_cyc - start_cyc, 1);

    aw_stall = 0; w_stall = 0; b_stall = 0; s_gap = 0;
    src_base = n_w;
    for (int i = 0; i < 16; i++) gen[(n_w + i) % 1024] = $urandom;
    src_total = 16;
    i_start = 1'b1;
    i_base_addr = 'h200;
    i_n_pixels = 16;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < 200 && n_w - src_base < 4; c++) @(negedge clk);
    chk("beats_before_rst", n_w - src_base, 4);
    rst = 1'b1;
    src_total = 0;
    @(negedge clk);
    chk("midrst_awvalid", bus.awvalid, 0);
    chk("midrst_wvalid", bus.wvalid, 0);
    chk("midrst_bready", bus.bready, 0);
    chk("midrst_s_ready", bus.s_ready, 0);
    chk("midrst_busy", o_busy, 0);
    rst = 1'b0;
    @(negedge clk);
    run_cmd('h0200, 16, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
